vc_queue_pf: RTL and testbench

VC_QUEUE_PF -- requirements
Module: vc_queue_pf

---
 rtl/vc_queue_pkg.sv | 14 +
 rtl/vcRAM_1w1r_pf.sv | 26 ++
 rtl/vc_queue_pf.sv | 84 ++++++++
 tb/tb_vc_queue_pf.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vc_queue_pkg.sv
// Shared helpers for the vc_queue_pf family: pointer increment with wrap
// for arbitrary depths, and the RTL-ERROR message text.
package vc_queue_pkg;

  localparam string RTL_ERROR_DEPTH =
    "RTL-ERROR: vc_queue_pf: (1<<ADDR_SZ) < ENTRIES, pointer too narrow for depth";

  // Wraps at an arbitrary depth, so ENTRIES need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned entries);
    return (ptr >= entries - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/vcRAM_1w1r_pf.sv
// One-write/one-read register-file storage for vc_queue_pf: synchronous
// write, combinational read, contents never reset.
module vcRAM_1w1r_pf #(
  parameter int DATA_SZ = 8,
  parameter int ENTRIES = 4,
  parameter int ADDR_SZ = 2
) (
  input  logic               clk,
  input  logic [ADDR_SZ-1:0] raddr,
  output logic [DATA_SZ-1:0] rdata,
  input  logic               wen_p,
  input  logic [ADDR_SZ-1:0] waddr_p,
  input  logic [DATA_SZ-1:0] wdata_p
);

  logic [DATA_SZ-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (wen_p) begin
      mem[waddr_p] <= wdata_p;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vc_queue_pf.sv
// Valid/ready FIFO with 1-cycle latency, synchronous active-low reset.
// Define VC_QUEUE_PIPE_EN to let a full queue accept while its head drains.
module vc_queue_pf
  import vc_queue_pkg::*;
#(
  parameter int DATA_SZ = 8,
  parameter int ENTRIES = 4,
  parameter int ADDR_SZ = 2
) (
  input  logic               clk,
  input  logic               resetn_p,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [DATA_SZ-1:0] enq_bits,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [DATA_SZ-1:0] deq_bits,
  output logic [ADDR_SZ:0]   count
);

  localparam logic [ADDR_SZ:0] FULL_CNT = (ADDR_SZ+1)'(ENTRIES);

  logic [ADDR_SZ-1:0] wptr;
  logic [ADDR_SZ-1:0] rptr;
  logic [ADDR_SZ:0]   cnt_q;
  logic               enq_fire;
  logic               deq_fire;

  always_comb begin
    deq_val = resetn_p && (cnt_q != '0);
`ifdef VC_QUEUE_PIPE_EN
    // Full-and-draining is safe: the write lands in the slot the head vacates.
    enq_rdy = resetn_p && ((cnt_q != FULL_CNT) || deq_rdy);
`else
    enq_rdy = resetn_p && (cnt_q != FULL_CNT);
`endif
  end

  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;
  assign count    = cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn_p) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
    end else begin
      if (enq_fire) begin
        wptr <= ADDR_SZ'(ptr_inc(32'(wptr), ENTRIES));
      end
      if (deq_fire) begin
        rptr <= ADDR_SZ'(ptr_inc(32'(rptr), ENTRIES));
      end
      if (enq_fire && !deq_fire) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!enq_fire && deq_fire) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  vcRAM_1w1r_pf #(
    .DATA_SZ (DATA_SZ),
    .ENTRIES (ENTRIES),
    .ADDR_SZ (ADDR_SZ)
  ) u_ram (
    .clk     (clk),
    .raddr   (rptr),
    .rdata   (deq_bits),
    .wen_p   (enq_fire),
    .waddr_p (wptr),
    .wdata_p (enq_bits)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if ((1 << ADDR_SZ) < ENTRIES) begin
      $display("%s", RTL_ERROR_DEPTH);
    end
  end
`endif

endmodule

// File: tb/tb_vc_queue_pf.sv
// Self-checking bench for vc_queue_pf at depths 4, 3 and 5 (3-bit pointers);
// expectations follow VC_QUEUE_PIPE_EN when it is defined.
module tb_vc_queue_pf;

`ifdef VC_QUEUE_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn_p;
  int   total = 0;
  int   bad   = 0;

  logic       e4_val, e4_rdy, d4_val, d4_rdy;
  logic [7:0] e4_bits, d4_bits;
  logic [2:0] c4;
  logic       e3_val, e3_rdy, d3_val, d3_rdy;
  logic [7:0] e3_bits, d3_bits;
  logic [2:0] c3;
  logic       e5_val, e5_rdy, d5_val, d5_rdy;
  logic [7:0] e5_bits, d5_bits;
  logic [3:0] c5;

  vc_queue_pf #(.DATA_SZ(8), .ENTRIES(4), .ADDR_SZ(2)) u4 (
    .clk(clk), .resetn_p(resetn_p), .enq_val(e4_val), .enq_rdy(e4_rdy),
    .enq_bits(e4_bits), .deq_val(d4_val), .deq_rdy(d4_rdy),
    .deq_bits(d4_bits), .count(c4));

  vc_queue_pf #(.DATA_SZ(8), .ENTRIES(3), .ADDR_SZ(2)) u3 (
    .clk(clk), .resetn_p(resetn_p), .enq_val(e3_val), .enq_rdy(e3_rdy),
    .enq_bits(e3_bits), .deq_val(d3_val), .deq_rdy(d3_rdy),
    .deq_bits(d3_bits), .count(c3));

  vc_queue_pf #(.DATA_SZ(8), .ENTRIES(5), .ADDR_SZ(3)) u5 (
    .clk(clk), .resetn_p(resetn_p), .enq_val(e5_val), .enq_rdy(e5_rdy),
    .enq_bits(e5_bits), .deq_val(d5_val), .deq_rdy(d5_rdy),
    .deq_bits(d5_bits), .count(c5));

  task automatic test_reset();
    resetn_p = 1'b0;
    e4_val = 1'b1; e4_bits = 8'hEE; d4_rdy = 1'b1;
    e3_val = 1'b0; e3_bits = '0; d3_rdy = 1'b0;
    e5_val = 1'b0; e5_bits = '0; d5_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (e4_rdy !== 1'b0) begin bad++; $display("FAIL rst_enq_rdy: got %b want 0", e4_rdy); end
    total++; if (d4_val !== 1'b0) begin bad++; $display("FAIL rst_deq_val: got %b want 0", d4_val); end
    @(negedge clk);
    resetn_p = 1'b1; e4_val = 1'b0; d4_rdy = 1'b0;
    @(negedge clk); #1;
    total++; if (e4_rdy !== 1'b1) begin bad++; $display("FAIL post_rst_enq_rdy: got %b want 1", e4_rdy); end
    total++; if (d4_val !== 1'b0) begin bad++; $display("FAIL post_rst_deq_val: got %b want 0", d4_val); end
    total++; if (c4 !== 3'd0) begin bad++; $display("FAIL post_rst_count4: got %0d want 0", c4); end
    total++; if (c3 !== 3'd0) begin bad++; $display("FAIL post_rst_count3: got %0d want 0", c3); end
    total++; if (c5 !== 4'd0) begin bad++; $display("FAIL post_rst_count5: got %0d want 0", c5); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] v [4];
    v = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e4_val = 1'b1; e4_bits = v[i]; d4_rdy = 1'b0; #1;
      total++; if (e4_rdy !== 1'b1) begin bad++; $display("FAIL fill_enq_rdy[%0d]: got %b want 1", i, e4_rdy); end
      total++; if (c4 !== 3'(i)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, c4, i); end
    end
    @(negedge clk);
    e4_val = 1'b0; #1;
    total++; if (c4 !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", c4); end
    total++; if (e4_rdy !== 1'b0) begin bad++; $display("FAIL full_enq_rdy: got %b want 0", e4_rdy); end
    for (int i = 0; i < 4; i++) begin
      d4_rdy = 1'b1; #1;
      total++; if (d4_val !== 1'b1) begin bad++; $display("FAIL drain_val[%0d]: got %b want 1", i, d4_val); end
      total++; if (d4_bits !== v[i]) begin bad++; $display("FAIL drain_bits[%0d]: got %h want %h", i, d4_bits, v[i]); end
      @(negedge clk);
    end
    d4_rdy = 1'b0; #1;
    total++; if (d4_val !== 1'b0) begin bad++; $display("FAIL drained_val: got %b want 0", d4_val); end
    total++; if (c4 !== 3'd0) begin bad++; $display("FAIL drained_count: got %0d want 0", c4); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    e3_val = 1'b1; e3_bits = 8'd0; d3_rdy = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      e3_bits = 8'(i); d3_rdy = 1'b1; #1;
      total++; if (c3 !== 3'd1) begin bad++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, c3); end
      total++; if (d3_bits !== 8'(i - 1)) begin bad++; $display("FAIL wrap_bits[%0d]: got %0d want %0d", i, d3_bits, i - 1); end
      total++; if (e3_rdy !== 1'b1 || d3_val !== 1'b1) begin bad++; $display("FAIL wrap_hs[%0d]: got rdy=%b val=%b want 1/1", i, e3_rdy, d3_val); end
    end
    @(negedge clk);
    e3_val = 1'b0; d3_rdy = 1'b1; #1;
    total++; if (d3_bits !== 8'd9) begin bad++; $display("FAIL wrap_last: got %0d want 9", d3_bits); end
    total++; if (c3 !== 3'd1) begin bad++; $display("FAIL wrap_last_count: got %0d want 1", c3); end
    @(negedge clk);
    d3_rdy = 1'b0; #1;
    total++; if (c3 !== 3'd0 || d3_val !== 1'b0) begin bad++; $display("FAIL wrap_empty: got cnt=%0d val=%b want 0/0", c3, d3_val); end
  endtask

  task automatic test_empty_simul();
    @(negedge clk);
    e4_val = 1'b1; e4_bits = 8'hA5; d4_rdy = 1'b1; #1;
    total++; if (d4_val !== 1'b0) begin bad++; $display("FAIL empty_deq_val: got %b want 0", d4_val); end
    total++; if (e4_rdy !== 1'b1) begin bad++; $display("FAIL empty_enq_rdy: got %b want 1", e4_rdy); end
    @(negedge clk);
    e4_val = 1'b0; d4_rdy = 1'b0; #1;
    total++; if (d4_val !== 1'b1) begin bad++; $display("FAIL latency_val: got %b want 1", d4_val); end
    total++; if (d4_bits !== 8'hA5) begin bad++; $display("FAIL latency_bits: got %h want a5", d4_bits); end
    total++; if (c4 !== 3'd1) begin bad++; $display("FAIL latency_count: got %0d want 1", c4); end
    d4_rdy = 1'b1;
    @(negedge clk);
    d4_rdy = 1'b0; #1;
    total++; if (c4 !== 3'd0) begin bad++; $display("FAIL empty_after: got %0d want 0", c4); end
  endtask

  task automatic test_full_simul();
    logic [7:0] q [$];
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      e4_val = 1'b1; e4_bits = 8'(i); d4_rdy = 1'b0;
      q.push_back(8'(i));
    end
    @(negedge clk);
    e4_val = 1'b0; #1;
    total++; if (c4 !== 3'd4) begin bad++; $display("FAIL fs_count_pre: got %0d want 4", c4); end
    e4_val = 1'b1; e4_bits = 8'h77; d4_rdy = 1'b1; #1;
    total++; if (e4_rdy !== PIPE) begin bad++; $display("FAIL fs_enq_rdy: got %b want %b", e4_rdy, PIPE); end
    total++; if (d4_bits !== 8'h01) begin bad++; $display("FAIL fs_head: got %h want 01", d4_bits); end
    void'(q.pop_front());
    if (PIPE) q.push_back(8'h77);
    @(negedge clk);
    e4_val = 1'b0; #1;
    total++; if (c4 !== 3'(q.size())) begin bad++; $display("FAIL fs_count_post: got %0d want %0d", c4, q.size()); end
    while (q.size() != 0) begin
      total++; if (d4_bits !== q[0]) begin bad++; $display("FAIL fs_order: got %h want %h", d4_bits, q[0]); end
      void'(q.pop_front());
      @(negedge clk); #1;
    end
    d4_rdy = 1'b0; #1;
    total++; if (d4_val !== 1'b0) begin bad++; $display("FAIL fs_drained: got %b want 0", d4_val); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e4_val = 1'b1; e4_bits = 8'h31 + 8'(i); d4_rdy = 1'b0;
    end
    @(negedge clk);
    e4_val = 1'b0; #1;
    total++; if (c4 !== 3'd2) begin bad++; $display("FAIL rm_count_pre: got %0d want 2", c4); end
    resetn_p = 1'b0; e4_val = 1'b1; e4_bits = 8'h99; #1;
    total++; if (e4_rdy !== 1'b0) begin bad++; $display("FAIL rm_enq_rdy: got %b want 0", e4_rdy); end
    total++; if (d4_val !== 1'b0) begin bad++; $display("FAIL rm_deq_val: got %b want 0", d4_val); end
    @(negedge clk);
    resetn_p = 1'b1; e4_val = 1'b0; d4_rdy = 1'b1; #1;
    total++; if (c4 !== 3'd0) begin bad++; $display("FAIL rm_count_post: got %0d want 0", c4); end
    total++; if (d4_val !== 1'b0) begin bad++; $display("FAIL rm_stale_val: got %b want 0", d4_val); end
    total++; if (e4_rdy !== 1'b1) begin bad++; $display("FAIL rm_enq_rdy_post: got %b want 1", e4_rdy); end
    e4_val = 1'b1; e4_bits = 8'h5A;
    @(negedge clk);
    e4_val = 1'b0; #1;
    total++; if (d4_val !== 1'b1 || d4_bits !== 8'h5A) begin bad++; $display("FAIL rm_first: got val=%b bits=%h want 1/5a", d4_val, d4_bits); end
    @(negedge clk);
    d4_rdy = 1'b0; #1;
    total++; if (c4 !== 3'd0) begin bad++; $display("FAIL rm_final_count: got %0d want 0", c4); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic       exp_rdy, exp_val, ev, dr;
    int         p_enq;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      p_enq = ((n / 100) % 2 == 0) ? 75 : 30;
      ev = ($urandom % 100) < p_enq;
      dr = ($urandom % 100) < 50;
      e5_val = ev; d5_rdy = dr; e5_bits = 8'($urandom);
      #1;
      exp_val = (q.size() != 0);
      exp_rdy = (q.size() != 5) || (PIPE && dr);
      total++; if (e5_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_enq_rdy@%0d: got %b want %b", n, e5_rdy, exp_rdy); end
      total++; if (d5_val !== exp_val) begin bad++; $display("FAIL rnd_deq_val@%0d: got %b want %b", n, d5_val, exp_val); end
      total++; if (c5 !== 4'(q.size())) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, c5, q.size()); end
      total++; if (c5 > 4'd5) begin bad++; $display("FAIL rnd_count_max@%0d: got %0d want <=5", n, c5); end
      if (q.size() != 0) begin
        total++; if (d5_bits !== q[0]) begin bad++; $display("FAIL rnd_bits@%0d: got %h want %h", n, d5_bits, q[0]); end
      end
      if (exp_val && dr) void'(q.pop_front());
      if (exp_rdy && ev) q.push_back(e5_bits);
    end
    @(negedge clk);
    e5_val = 1'b0; d5_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_empty_simul();
    test_full_simul();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
